// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and writeback source indices
package rf_wb_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int REG_IDX_W  = 5;
  localparam int NUM_REGS   = 32;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;
  localparam int WB_NUM_SRC = 3;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback, issue and register-file port bundle
interface rf_wb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 64
);
  import rf_wb_arbiter_pkg::*;

  logic [NUM_SRC-1:0]                wb_valid_i;
  logic [NUM_SRC-1:0][REG_IDX_W-1:0] wb_rd_i;
  logic [NUM_SRC-1:0][XLEN-1:0]      wb_data_i;
  logic [NUM_SRC-1:0]                wb_ready_o;
  logic                              issue_valid_i;
  logic [REG_IDX_W-1:0]              issue_rd_i;
  logic [NUM_REGS-1:0]               busy_o;
  logic                              rf_wr_en_o;
  logic [REG_IDX_W-1:0]              rf_rd_idx_o;
  logic [XLEN-1:0]                   rf_wr_data_o;

  // Execute/memory units and issue logic side
  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i, issue_valid_i, issue_rd_i,
    input  wb_ready_o, busy_o, rf_wr_en_o, rf_rd_idx_o, rf_wr_data_o
  );

  // Arbiter side
  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i, issue_valid_i, issue_rd_i,
    output wb_ready_o, busy_o, rf_wr_en_o, rf_rd_idx_o, rf_wr_data_o
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rtl/rf_wb_arbiter_rr_arbiter.sv - combinational round-robin grant from request vector and pointer
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  // Scan requests starting at the pointer, wrapping modulo NUM_REQ; first hit wins
  always_comb begin
    int unsigned cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
module rf_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rf_wb_arbiter_if.slave wb
);
  import rf_wb_arbiter_pkg::*;

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]     rr_q;
  logic [PTR_W-1:0]     rr_next;
  logic [NUM_SRC-1:0]   gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_valid;

  logic                 wr_en_q;
  logic [REG_IDX_W-1:0] rd_idx_q;
  logic [XLEN-1:0]      wr_data_q;

  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (wb.wb_valid_i),
    .ptr       (rr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Grant is only ever raised for a valid source, so grant implies transfer
  assign wb.wb_ready_o   = gnt;
  assign wb.rf_wr_en_o   = wr_en_q;
  assign wb.rf_rd_idx_o  = rd_idx_q;
  assign wb.rf_wr_data_o = wr_data_q;
  assign wb.busy_o       = busy_q;

  // Pointer moves to the source just after the winner so it has lowest priority next
  always_comb begin
    rr_next = '0;
    if (int'(gnt_idx) != NUM_SRC - 1) begin
      rr_next = gnt_idx + 1'b1;
    end
  end

  // Output stage: latch the winner; writes to x0 are consumed but never enabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      rd_idx_q  <= '0;
      wr_data_q <= '0;
    end else if (gnt_valid) begin
      rr_q      <= rr_next;
      wr_en_q   <= |wb.wb_rd_i[gnt_idx];
      rd_idx_q  <= wb.wb_rd_i[gnt_idx];
      wr_data_q <= wb.wb_data_i[gnt_idx];
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  // Scoreboard next state: retire the write on the port, then a new issue overrides
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[rd_idx_q] = 1'b0;
    end
    if (wb.issue_valid_i && (wb.issue_rd_i != '0)) begin
      busy_d[wb.issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; pending bits are dropped on reset with the pipeline flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hazard_cnt = 0;

  logic [XLEN-1:0] rf_model [NUM_REGS];

  rf_wb_arbiter_if #(.NUM_SRC(WB_NUM_SRC), .XLEN(XLEN)) ifc ();

  rf_wb_arbiter #(.NUM_SRC(WB_NUM_SRC), .XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file stand-in: commits on the negedge of the cycle the port is driven
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_model[i] <= '0;
    end else if (ifc.rf_wr_en_o && ifc.rf_rd_idx_o != 0) begin
      rf_model[ifc.rf_rd_idx_o] <= ifc.rf_wr_data_o;
    end
  end

  function automatic logic [XLEN-1:0] read_rf(input logic [REG_IDX_W-1:0] idx);
    return (idx == 0) ? '0 : rf_model[idx];
  endfunction

  // Issue to a busy register is only legal when that register retires the same cycle
  always @(negedge clk) begin
    #4;
    if (!rst && ifc.issue_valid_i && ifc.issue_rd_i != 0 && ifc.busy_o[ifc.issue_rd_i] &&
        !(ifc.rf_wr_en_o && ifc.rf_rd_idx_o == ifc.issue_rd_i)) begin
      hazard_cnt = hazard_cnt + 1;
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.wb_valid_i    = '0;
    ifc.wb_rd_i       = '0;
    ifc.wb_data_i     = '0;
    ifc.issue_valid_i = 1'b0;
    ifc.issue_rd_i    = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_all_valid();
    ifc.wb_valid_i = 3'b111;
    ifc.wb_rd_i[WB_SRC_ALU]   = 5'd1;
    ifc.wb_rd_i[WB_SRC_LSU]   = 5'd2;
    ifc.wb_rd_i[WB_SRC_MDU]   = 5'd3;
    ifc.wb_data_i[WB_SRC_ALU] = 64'h1111;
    ifc.wb_data_i[WB_SRC_LSU] = 64'h2222;
    ifc.wb_data_i[WB_SRC_MDU] = 64'h3333;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b expected 0", ifc.rf_wr_en_o); end
    n_cmp++; if (ifc.rf_rd_idx_o !== 5'd0) begin n_bad++; $display("FAIL reset_rd_idx: got %0d expected 0", ifc.rf_rd_idx_o); end
    n_cmp++; if (ifc.rf_wr_data_o !== 64'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h expected 0", ifc.rf_wr_data_o); end
    n_cmp++; if (ifc.busy_o !== 32'h0) begin n_bad++; $display("FAIL reset_busy: got %h expected 0", ifc.busy_o); end
    n_cmp++; if (ifc.wb_ready_o !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b expected 000", ifc.wb_ready_o); end
    n_cmp++; if (dut.rr_q !== 2'd0) begin n_bad++; $display("FAIL reset_rr: got %0d expected 0", dut.rr_q); end
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    ifc.wb_valid_i[WB_SRC_ALU] = 1'b1;
    ifc.wb_rd_i[WB_SRC_ALU]    = 5'd5;
    ifc.wb_data_i[WB_SRC_ALU]  = 64'hDEAD_BEEF;
    #1;
    n_cmp++; if (ifc.wb_ready_o !== 3'b001) begin n_bad++; $display("FAIL single_ready: got %b expected 001", ifc.wb_ready_o); end
    next_cycle();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b1) begin n_bad++; $display("FAIL single_wr_en: got %b expected 1", ifc.rf_wr_en_o); end
    n_cmp++; if (ifc.rf_rd_idx_o !== 5'd5) begin n_bad++; $display("FAIL single_rd_idx: got %0d expected 5", ifc.rf_rd_idx_o); end
    n_cmp++; if (ifc.rf_wr_data_o !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL single_wr_data: got %h expected deadbeef", ifc.rf_wr_data_o); end
    n_cmp++; if (read_rf(5'd5) !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rf_x5: got %h expected deadbeef", read_rf(5'd5)); end
    clear_inputs();
    next_cycle();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL single_idle_wr_en: got %b expected 0", ifc.rf_wr_en_o); end
    n_cmp++; if (ifc.rf_rd_idx_o !== 5'd5) begin n_bad++; $display("FAIL single_idle_hold_idx: got %0d expected 5", ifc.rf_rd_idx_o); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0]  exp_idx [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    logic [63:0] exp_dat [6] = '{64'h1111, 64'h2222, 64'h3333, 64'h1111, 64'h2222, 64'h3333};
    pulse_reset();
    set_all_valid();
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (ifc.wb_ready_o !== exp_gnt[i]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, ifc.wb_ready_o, exp_gnt[i]); end
      next_cycle();
      n_cmp++; if (ifc.rf_wr_en_o !== 1'b1 || ifc.rf_rd_idx_o !== exp_idx[i] || ifc.rf_wr_data_o !== exp_dat[i]) begin
        n_bad++; $display("FAIL rr_port[%0d]: got en=%b idx=%0d data=%h expected en=1 idx=%0d data=%h",
                          i, ifc.rf_wr_en_o, ifc.rf_rd_idx_o, ifc.rf_wr_data_o, exp_idx[i], exp_dat[i]);
      end
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_x0_drop();
    ifc.wb_valid_i[WB_SRC_LSU] = 1'b1;
    ifc.wb_rd_i[WB_SRC_LSU]    = 5'd0;
    ifc.wb_data_i[WB_SRC_LSU]  = 64'h1234;
    #1;
    n_cmp++; if (ifc.wb_ready_o !== 3'b010) begin n_bad++; $display("FAIL x0_ready: got %b expected 010", ifc.wb_ready_o); end
    next_cycle();
    clear_inputs();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL x0_wr_en: got %b expected 0", ifc.rf_wr_en_o); end
    n_cmp++; if (ifc.rf_wr_data_o !== 64'h1234) begin n_bad++; $display("FAIL x0_data_loaded: got %h expected 1234", ifc.rf_wr_data_o); end
    n_cmp++; if (ifc.busy_o !== 32'h0) begin n_bad++; $display("FAIL x0_busy: got %h expected 0", ifc.busy_o); end
    n_cmp++; if (read_rf(5'd0) !== 64'h0) begin n_bad++; $display("FAIL x0_read: got %h expected 0", read_rf(5'd0)); end
  endtask

  task automatic test_scoreboard();
    ifc.issue_valid_i = 1'b1;
    ifc.issue_rd_i    = 5'd7;
    next_cycle();
    ifc.issue_valid_i = 1'b0;
    n_cmp++; if (ifc.busy_o !== 32'h0000_0080) begin n_bad++; $display("FAIL sb_set: got %h expected 00000080", ifc.busy_o); end
    next_cycle();
    next_cycle();
    n_cmp++; if (ifc.busy_o !== 32'h0000_0080) begin n_bad++; $display("FAIL sb_hold: got %h expected 00000080", ifc.busy_o); end
    ifc.wb_valid_i[WB_SRC_MDU] = 1'b1;
    ifc.wb_rd_i[WB_SRC_MDU]    = 5'd7;
    ifc.wb_data_i[WB_SRC_MDU]  = 64'h77;
    #1;
    n_cmp++; if (ifc.wb_ready_o !== 3'b100) begin n_bad++; $display("FAIL sb_mdu_ready: got %b expected 100", ifc.wb_ready_o); end
    next_cycle();
    clear_inputs();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b1 || ifc.rf_rd_idx_o !== 5'd7) begin n_bad++; $display("FAIL sb_port: got en=%b idx=%0d expected en=1 idx=7", ifc.rf_wr_en_o, ifc.rf_rd_idx_o); end
    n_cmp++; if (ifc.busy_o !== 32'h0000_0080) begin n_bad++; $display("FAIL sb_not_yet_clear: got %h expected 00000080", ifc.busy_o); end
    ifc.issue_valid_i = 1'b1;
    ifc.issue_rd_i    = 5'd7;
    next_cycle();
    ifc.issue_valid_i = 1'b0;
    n_cmp++; if (ifc.busy_o !== 32'h0000_0080) begin n_bad++; $display("FAIL sb_set_wins: got %h expected 00000080", ifc.busy_o); end
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL sb_port_idle: got %b expected 0", ifc.rf_wr_en_o); end
    ifc.wb_valid_i[WB_SRC_MDU] = 1'b1;
    ifc.wb_rd_i[WB_SRC_MDU]    = 5'd7;
    ifc.wb_data_i[WB_SRC_MDU]  = 64'h78;
    next_cycle();
    clear_inputs();
    n_cmp++; if (ifc.busy_o !== 32'h0000_0080) begin n_bad++; $display("FAIL sb_retire_pending: got %h expected 00000080", ifc.busy_o); end
    next_cycle();
    n_cmp++; if (ifc.busy_o !== 32'h0) begin n_bad++; $display("FAIL sb_clear: got %h expected 0", ifc.busy_o); end
    n_cmp++; if (read_rf(5'd7) !== 64'h78) begin n_bad++; $display("FAIL sb_rf_x7: got %h expected 78", read_rf(5'd7)); end
  endtask

  task automatic test_async_reset();
    ifc.issue_valid_i = 1'b1;
    ifc.issue_rd_i    = 5'd7;
    next_cycle();
    ifc.issue_valid_i = 1'b0;
    ifc.wb_valid_i[WB_SRC_ALU] = 1'b1;
    ifc.wb_rd_i[WB_SRC_ALU]    = 5'd7;
    ifc.wb_data_i[WB_SRC_ALU]  = 64'hAA;
    next_cycle();
    clear_inputs();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b1 || ifc.busy_o !== 32'h0000_0080) begin
      n_bad++; $display("FAIL ar_precond: got en=%b busy=%h expected en=1 busy=00000080", ifc.rf_wr_en_o, ifc.busy_o);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b0 || ifc.rf_rd_idx_o !== 5'd0 || ifc.rf_wr_data_o !== 64'h0) begin
      n_bad++; $display("FAIL ar_port: got en=%b idx=%0d data=%h expected all 0", ifc.rf_wr_en_o, ifc.rf_rd_idx_o, ifc.rf_wr_data_o);
    end
    n_cmp++; if (ifc.busy_o !== 32'h0) begin n_bad++; $display("FAIL ar_busy: got %h expected 0", ifc.busy_o); end
    n_cmp++; if (dut.rr_q !== 2'd0) begin n_bad++; $display("FAIL ar_rr: got %0d expected 0", dut.rr_q); end
    n_cmp++; if (ifc.wb_ready_o !== 3'b000) begin n_bad++; $display("FAIL ar_ready: got %b expected 000", ifc.wb_ready_o); end
    next_cycle();
    rst = 1'b0;
    set_all_valid();
    #1;
    n_cmp++; if (ifc.wb_ready_o !== 3'b001) begin n_bad++; $display("FAIL ar_first_grant: got %b expected 001", ifc.wb_ready_o); end
    next_cycle();
    clear_inputs();
    n_cmp++; if (ifc.rf_wr_en_o !== 1'b1 || ifc.rf_rd_idx_o !== 5'd1) begin n_bad++; $display("FAIL ar_first_write: got en=%b idx=%0d expected en=1 idx=1", ifc.rf_wr_en_o, ifc.rf_rd_idx_o); end
    next_cycle();
  endtask

  task automatic test_hazard_monitor();
    n_cmp++; if (hazard_cnt !== 0) begin n_bad++; $display("FAIL issue_to_busy: got %0d illegal issues expected 0", hazard_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_source();
    test_round_robin();
    test_x0_drop();
    test_scoreboard();
    test_async_reset();
    test_hazard_monitor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
